// File: rtl/alu_exec_ctrl_if.sv
// Bundle of the instruction handshake, register-file ports, ALU ports and
// status outputs of the ALU execution controller.
interface alu_exec_ctrl_if #(
  parameter int WIDTH_DATA    = 16,
  parameter int WIDTH_CONTROL = 4,
  parameter int WIDTH_ADDR    = 4
);
  logic                     instr_valid;
  logic                     instr_ready;
  logic [WIDTH_CONTROL-1:0] instr_op;
  logic [WIDTH_ADDR-1:0]    instr_rdest;
  logic [WIDTH_ADDR-1:0]    instr_rsrc;
  logic                     instr_imm_en;
  logic [WIDTH_DATA-1:0]    instr_imm;
  logic                     instr_cin_en;

  logic [WIDTH_ADDR-1:0]    rf_raddr_a;
  logic [WIDTH_ADDR-1:0]    rf_raddr_b;
  logic [WIDTH_DATA-1:0]    rf_rdata_a;
  logic [WIDTH_DATA-1:0]    rf_rdata_b;
  logic                     rf_we;
  logic [WIDTH_ADDR-1:0]    rf_waddr;
  logic [WIDTH_DATA-1:0]    rf_wdata;

  logic [WIDTH_DATA-1:0]    alu_A;
  logic [WIDTH_DATA-1:0]    alu_B;
  logic [WIDTH_CONTROL-1:0] alu_control;
  logic                     alu_carry_in;
  logic [WIDTH_DATA-1:0]    alu_result;
  logic                     alu_carry_out;
  logic                     alu_low_out;
  logic                     alu_over_out;
  logic                     alu_neg_out;
  logic                     alu_zero_out;

  logic [4:0]               psr;
  logic                     done;
  logic                     err;

  // Controller side
  modport slave (
    input  instr_valid, instr_op, instr_rdest, instr_rsrc, instr_imm_en,
           instr_imm, instr_cin_en, rf_rdata_a, rf_rdata_b, alu_result,
           alu_carry_out, alu_low_out, alu_over_out, alu_neg_out, alu_zero_out,
    output instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
           alu_A, alu_B, alu_control, alu_carry_in, psr, done, err
  );

  // Decode / register file / ALU side
  modport master (
    output instr_valid, instr_op, instr_rdest, instr_rsrc, instr_imm_en,
           instr_imm, instr_cin_en, rf_rdata_a, rf_rdata_b, alu_result,
           alu_carry_out, alu_low_out, alu_over_out, alu_neg_out, alu_zero_out,
    input  instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
           alu_A, alu_B, alu_control, alu_carry_in, psr, done, err
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Four-state sequencer (IDLE/READ/EXEC/WB) running one ALU instruction at a
// time: register-file read, ALU drive, write-back and PSR {C,L,F,N,Z} update.
module alu_exec_ctrl #(
  parameter int WIDTH_DATA    = 16,
  parameter int WIDTH_CONTROL = 4,
  parameter int WIDTH_ADDR    = 4
) (
  input logic           clk,
  input logic           reset,
  alu_exec_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  localparam logic [WIDTH_CONTROL-1:0] OP_ADD  = WIDTH_CONTROL'(0);
  localparam logic [WIDTH_CONTROL-1:0] OP_ADDU = WIDTH_CONTROL'(1);
  localparam logic [WIDTH_CONTROL-1:0] OP_SUB  = WIDTH_CONTROL'(2);
  localparam logic [WIDTH_CONTROL-1:0] OP_SUBU = WIDTH_CONTROL'(3);
  localparam logic [WIDTH_CONTROL-1:0] OP_CMP  = WIDTH_CONTROL'(4);
  localparam logic [WIDTH_CONTROL-1:0] OP_AND  = WIDTH_CONTROL'(5);
  localparam logic [WIDTH_CONTROL-1:0] OP_OR   = WIDTH_CONTROL'(6);
  localparam logic [WIDTH_CONTROL-1:0] OP_XOR  = WIDTH_CONTROL'(7);
  localparam logic [WIDTH_CONTROL-1:0] OP_LSH  = WIDTH_CONTROL'(8);

  state_t                   state_q, state_d;
  logic [WIDTH_CONTROL-1:0] op_q, op_d;
  logic [WIDTH_ADDR-1:0]    rdest_q, rdest_d;
  logic                     imm_en_q, imm_en_d;
  logic [WIDTH_DATA-1:0]    imm_q, imm_d;
  logic                     cin_en_q, cin_en_d;
  logic [WIDTH_ADDR-1:0]    raddr_a_q, raddr_a_d;
  logic [WIDTH_ADDR-1:0]    raddr_b_q, raddr_b_d;
  logic [WIDTH_DATA-1:0]    alu_a_q, alu_a_d;
  logic [WIDTH_DATA-1:0]    alu_b_q, alu_b_d;
  logic [WIDTH_CONTROL-1:0] alu_ctl_q, alu_ctl_d;
  logic                     alu_cin_q, alu_cin_d;
  logic [WIDTH_DATA-1:0]    res_q, res_d;
  logic [4:0]               flags_q, flags_d;
  logic [4:0]               psr_q, psr_d;
  logic                     rf_we_q, rf_we_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic [WIDTH_DATA-1:0]    exec_a;
  logic [WIDTH_DATA-1:0]    exec_b;
  logic                     exec_cin;

  // Merge the ALU flags into the PSR, touching only the bits the op owns
  function automatic logic [4:0] psr_next(input logic [WIDTH_CONTROL-1:0] op,
                                          input logic [4:0] psr,
                                          input logic [4:0] flags);
    logic [4:0] mask;
    case (op)
      OP_ADDU, OP_SUBU:             mask = 5'b10001;  // C, Z
      OP_ADD, OP_SUB:               mask = 5'b00111;  // F, N, Z
      OP_CMP:                       mask = 5'b01011;  // L, N, Z
      OP_AND, OP_OR, OP_XOR, OP_LSH: mask = 5'b00011; // N, Z
      default:                      mask = 5'b00000;
    endcase
    return (psr & ~mask) | (flags & mask);
  endfunction

  // Operands presented to the ALU during EXEC; carry uses the committed PSR.C
  always_comb begin
    exec_a   = bus.rf_rdata_a;
    exec_b   = imm_en_q ? imm_q : bus.rf_rdata_b;
    exec_cin = cin_en_q & psr_q[4];
  end

  // Next-state and registered-output logic of the sequencer
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rdest_d   = rdest_q;
    imm_en_d  = imm_en_q;
    imm_d     = imm_q;
    cin_en_d  = cin_en_q;
    raddr_a_d = raddr_a_q;
    raddr_b_d = raddr_b_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_ctl_d = alu_ctl_q;
    alu_cin_d = alu_cin_q;
    res_d     = res_q;
    flags_d   = flags_q;
    psr_d     = psr_q;
    rf_we_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          op_d      = bus.instr_op;
          rdest_d   = bus.instr_rdest;
          imm_en_d  = bus.instr_imm_en;
          imm_d     = bus.instr_imm;
          cin_en_d  = bus.instr_cin_en;
          raddr_a_d = bus.instr_rdest;
          raddr_b_d = bus.instr_rsrc;
          state_d   = S_READ;
        end
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: begin
        alu_a_d   = exec_a;
        alu_b_d   = exec_b;
        alu_ctl_d = op_q;
        alu_cin_d = exec_cin;
        res_d     = bus.alu_result;
        flags_d   = {bus.alu_carry_out, bus.alu_low_out, bus.alu_over_out,
                     bus.alu_neg_out, bus.alu_zero_out};
        done_d    = 1'b1;
        if (op_q > OP_LSH) err_d = 1'b1;
        else if (op_q != OP_CMP) rf_we_d = 1'b1;
        state_d   = S_WB;
      end
      S_WB: begin
        psr_d   = psr_next(op_q, psr_q, flags_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rdest_q   <= '0;
      imm_en_q  <= 1'b0;
      imm_q     <= '0;
      cin_en_q  <= 1'b0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_ctl_q <= '0;
      alu_cin_q <= 1'b0;
      res_q     <= '0;
      flags_q   <= '0;
      psr_q     <= '0;
      rf_we_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rdest_q   <= rdest_d;
      imm_en_q  <= imm_en_d;
      imm_q     <= imm_d;
      cin_en_q  <= cin_en_d;
      raddr_a_q <= raddr_a_d;
      raddr_b_q <= raddr_b_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_ctl_q <= alu_ctl_d;
      alu_cin_q <= alu_cin_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
      psr_q     <= psr_d;
      rf_we_q   <= rf_we_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.instr_ready  = (state_q == S_IDLE);
  assign bus.rf_raddr_a   = raddr_a_q;
  assign bus.rf_raddr_b   = raddr_b_q;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rdest_q;
  assign bus.rf_wdata     = res_q;
  assign bus.alu_A        = (state_q == S_EXEC) ? exec_a   : alu_a_q;
  assign bus.alu_B        = (state_q == S_EXEC) ? exec_b   : alu_b_q;
  assign bus.alu_control  = (state_q == S_EXEC) ? op_q     : alu_ctl_q;
  assign bus.alu_carry_in = (state_q == S_EXEC) ? exec_cin : alu_cin_q;
  assign bus.psr          = psr_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: register-file and ALU models around the DUT, a
// vector table of instructions, a write-back scoreboard and corner sequences.
module tb_alu_exec_ctrl;
  logic clk;
  logic reset;

  alu_exec_ctrl_if bus();

  alu_exec_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        err;
    logic [4:0]  psr;
  } sb_t;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic        ie;
    logic [15:0] imm;
    logic        ce;
    logic        we;
    logic [15:0] wd;
    logic [4:0]  psr;
  } vec_t;

  sb_t         q[$];
  sb_t         cur;
  bit          pend;
  int          checks;
  int          errors;
  int          err_seen;
  logic [15:0] regs [16];
  vec_t        tv [12];

  logic [16:0] s;
  logic [15:0] res;
  logic        fc, fl, fo, fn, fz;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU
  always_comb begin
    s = '0; res = '0; fc = 1'b0; fl = 1'b0; fo = 1'b0; fn = 1'b0; fz = 1'b0;
    case (bus.alu_control)
      4'd0, 4'd1: begin
        s   = {1'b0, bus.alu_A} + {1'b0, bus.alu_B} + {16'd0, bus.alu_carry_in};
        res = s[15:0];
        fc  = s[16];
        fo  = (bus.alu_A[15] == bus.alu_B[15]) && (res[15] != bus.alu_A[15]);
      end
      4'd2, 4'd3: begin
        s   = {1'b0, bus.alu_A} - {1'b0, bus.alu_B} - {16'd0, bus.alu_carry_in};
        res = s[15:0];
        fc  = s[16];
        fo  = (bus.alu_A[15] != bus.alu_B[15]) && (res[15] != bus.alu_A[15]);
      end
      4'd4: begin
        res = bus.alu_A - bus.alu_B;
        fl  = bus.alu_A < bus.alu_B;
      end
      4'd5: res = bus.alu_A & bus.alu_B;
      4'd6: res = bus.alu_A | bus.alu_B;
      4'd7: res = bus.alu_A ^ bus.alu_B;
      4'd8: res = bus.alu_A << bus.alu_B[3:0];
      default: res = '0;
    endcase
    if (bus.alu_control == 4'd4) begin
      fn = $signed(bus.alu_A) < $signed(bus.alu_B);
      fz = bus.alu_A == bus.alu_B;
    end else begin
      fn = res[15];
      fz = (res == 16'd0);
    end
    bus.alu_result    = res;
    bus.alu_carry_out = fc;
    bus.alu_low_out   = fl;
    bus.alu_over_out  = fo;
    bus.alu_neg_out   = fn;
    bus.alu_zero_out  = fz;
  end

  // Register file: addresses and write port sampled mid-cycle, applied at the edge
  initial begin
    logic [3:0]  ra, rb, wa;
    logic [15:0] wd;
    logic        we;
    regs[0]  = 16'h0000; regs[1]  = 16'hFFFF; regs[2]  = 16'h0001; regs[3]  = 16'h7FFF;
    regs[4]  = 16'h0001; regs[5]  = 16'h0002; regs[6]  = 16'h0001; regs[7]  = 16'h0001;
    regs[8]  = 16'hFFFF; regs[9]  = 16'h0002; regs[10] = 16'h0001; regs[11] = 16'h0001;
    regs[12] = 16'hF0F0; regs[13] = 16'h8F00; regs[14] = 16'h0003; regs[15] = 16'h0005;
    bus.rf_rdata_a = '0;
    bus.rf_rdata_b = '0;
    forever begin
      @(negedge clk);
      ra = bus.rf_raddr_a; rb = bus.rf_raddr_b;
      we = bus.rf_we; wa = bus.rf_waddr; wd = bus.rf_wdata;
      @(posedge clk);
      bus.rf_rdata_a <= regs[ra];
      bus.rf_rdata_b <= regs[rb];
      if (we) regs[wa] = wd;
    end
  end

  // Write-back monitor: pops the scoreboard on each WB and checks PSR one cycle later
  initial begin
    pend = 0;
    err_seen = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 0;
      end else begin
        if (pend) begin
          check("psr", 32'(bus.psr), 32'(cur.psr));
          pend = 0;
        end
        if (bus.err) err_seen++;
        if (bus.done || bus.err || bus.rf_we) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wb: got done=%0b err=%0b we=%0b, expected none",
                     bus.done, bus.err, bus.rf_we);
          end else begin
            cur = q.pop_front();
            check("done", 32'(bus.done), 32'd1);
            check("err", 32'(bus.err), 32'(cur.err));
            check("rf_we", 32'(bus.rf_we), 32'(cur.we));
            if (cur.we) begin
              check("rf_waddr", 32'(bus.rf_waddr), 32'(cur.wa));
              check("rf_wdata", 32'(bus.rf_wdata), 32'(cur.wd));
            end
            pend = 1;
          end
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic ie, input logic [15:0] imm, input logic ce,
                       input bit push, input sb_t exp);
    int n = 0;
    @(negedge clk);
    while (!bus.instr_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_ready) begin
      check("issue_timeout", 32'(bus.instr_ready), 32'd1);
    end else begin
      bus.instr_op = op; bus.instr_rdest = rd; bus.instr_rsrc = rs;
      bus.instr_imm_en = ie; bus.instr_imm = imm; bus.instr_cin_en = ce;
      bus.instr_valid = 1'b1;
      if (push) q.push_back(exp);
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || pend) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("wait_idle_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    sb_t e;
    int  acc;
    int  err0;
    logic [7:0] pat;
    checks = 0;
    errors = 0;

    //          op    rd    rs    ie    imm       ce    we    wd         psr
    tv[0]  = '{4'd1, 4'd1, 4'd2, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 5'b10001};
    tv[1]  = '{4'd0, 4'd3, 4'd0, 1'b1, 16'h0001, 1'b0, 1'b1, 16'h8000, 5'b10110};
    tv[2]  = '{4'd4, 4'd4, 4'd5, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 5'b11110};
    tv[3]  = '{4'd1, 4'd6, 4'd7, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003, 5'b01110};
    tv[4]  = '{4'd1, 4'd8, 4'd9, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 5'b11110};
    tv[5]  = '{4'd1, 4'd10, 4'd11, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 5'b01110};
    tv[6]  = '{4'd7, 4'd12, 4'd12, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 5'b01101};
    tv[7]  = '{4'd6, 4'd13, 4'd0, 1'b1, 16'h00F0, 1'b0, 1'b1, 16'h8FF0, 5'b01110};
    tv[8]  = '{4'd8, 4'd14, 4'd0, 1'b1, 16'h0004, 1'b0, 1'b1, 16'h0030, 5'b01100};
    tv[9]  = '{4'd2, 4'd15, 4'd0, 1'b1, 16'h0005, 1'b0, 1'b1, 16'h0000, 5'b01001};
    tv[10] = '{4'd3, 4'd1, 4'd2, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 5'b11000};
    tv[11] = '{4'd5, 4'd13, 4'd12, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 5'b11001};

    bus.instr_valid = 1'b0; bus.instr_op = '0; bus.instr_rdest = '0; bus.instr_rsrc = '0;
    bus.instr_imm_en = 1'b0; bus.instr_imm = '0; bus.instr_cin_en = 1'b0;
    reset = 1'b0;

    // Reset with an instruction offered the whole time: it must be ignored
    #2 reset = 1'b1;
    bus.instr_valid = 1'b1; bus.instr_op = 4'd1; bus.instr_rdest = 4'd1; bus.instr_rsrc = 4'd2;
    @(negedge clk);
    check("rst_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_psr", 32'(bus.psr), 32'd0);
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_raddr_a", 32'(bus.rf_raddr_a), 32'd0);
    check("rst_alu_A", 32'(bus.alu_A), 32'd0);
    check("rst_alu_control", 32'(bus.alu_control), 32'd0);
    check("rst_rf_wdata", 32'(bus.rf_wdata), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0; bus.instr_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_ready", 32'(bus.instr_ready), 32'd1);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      e = '{we: tv[i].we, wa: tv[i].rd, wd: tv[i].wd, err: 1'b0, psr: tv[i].psr};
      issue(tv[i].op, tv[i].rd, tv[i].rs, tv[i].ie, tv[i].imm, tv[i].ce, 1'b1, e);
      wait_idle();
      check("alu_control_hold", 32'(bus.alu_control), 32'(tv[i].op));
    end
    check("cmp_keeps_r4", 32'(regs[4]), 32'h0001);

    // Illegal op offered continuously for 8 cycles: accepted every 4th cycle
    err0 = err_seen;
    acc = 0;
    pat = 8'b1000_1000;
    e = '{we: 1'b0, wa: 4'd1, wd: 16'h0000, err: 1'b1, psr: 5'b11001};
    @(negedge clk);
    bus.instr_op = 4'd9; bus.instr_rdest = 4'd1; bus.instr_rsrc = 4'd2;
    bus.instr_imm_en = 1'b0; bus.instr_cin_en = 1'b0;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      check("ready_pattern", 32'(bus.instr_ready), 32'(pat[7-i]));
      if (bus.instr_ready) begin
        q.push_back(e);
        acc++;
      end
    end
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("illegal_accepts", 32'(acc), 32'd2);
    check("err_pulses", 32'(err_seen - err0), 32'd2);
    check("illegal_keeps_r1", 32'(regs[1]), 32'hFFFF);

    // Reset during EXEC of SUB 8000-0001 discards it
    issue(4'd2, 4'd3, 4'd2, 1'b0, 16'h0000, 1'b0, 1'b0, e);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("midrst_ready", 32'(bus.instr_ready), 32'd1);
    check("midrst_psr", 32'(bus.psr), 32'd0);
    check("midrst_rf_we", 32'(bus.rf_we), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_keeps_r3", 32'(regs[3]), 32'h8000);
    check("midrst_idle", 32'(bus.instr_ready), 32'd1);

    // Next instruction runs normally from a cleared PSR
    e = '{we: 1'b1, wa: 4'd1, wd: 16'h0000, err: 1'b0, psr: 5'b10001};
    issue(4'd1, 4'd1, 4'd2, 1'b0, 16'h0000, 1'b0, 1'b1, e);
    wait_idle();
    check("sb_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
